wb_sdram: RTL and testbench

Wishbone classic responder for the board's 16-bit SDR SDRAM. It fills the decoder's SDRAM slave slot (stb/ack/dat) behind the CPU bus bridge. It turns each 32-bit Wishbone access into a close-page, burst-of-2 SDRAM transaction and handles power-up initialisation and periodic auto-refresh itself. The dq bus is split into i/o/t for the top-level IOBUF array; the sdram_clk pin is driven by ODDR2 at top level from the sdram_clk clock.

---
 rtl/wb_sdram.sv | 189 ++++++++++++++++++
 tb/tb_wb_sdram.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram.sv
// wb_sdram: Wishbone classic responder for a 16-bit SDR SDRAM.
// Each 32-bit access becomes a close-page burst-of-2 transaction
// (ACT, READ/WRITE with auto-precharge). Power-up init and periodic
// auto-refresh are sequenced internally.
module wb_sdram #(
  parameter int unsigned T_INIT = 10000,
  parameter int unsigned T_RP   = 2,
  parameter int unsigned T_RCD  = 2,
  parameter int unsigned T_RFC  = 7,
  parameter int unsigned T_WR   = 2,
  parameter int unsigned T_REFI = 390
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        sdram_cke,
  output logic        sdram_cs,
  output logic        sdram_ras,
  output logic        sdram_cas,
  output logic        sdram_we,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dm,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_t
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REFRESH, S_ACT, S_READ, S_WRITE, S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] a_q, a_d;
  logic [1:0]  ba_q, ba_d;
  logic [1:0]  dm_q, dm_d;
  logic [15:0] dq_o_q, dq_o_d;
  logic        dq_t_q, dq_t_d;
  logic [31:0] dat_q, dat_d;
  logic        cke_q, cke_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_run_q, ref_run_d;
  logic        ref_pend_q, ref_pend_d;

  // Upper word-address bits lie outside the 8M-word SDRAM window.
  logic unused_adr;
  assign unused_adr = ^adr_i[29:23];

  // Next-state, command and pin values; every SDRAM pin is registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    cmd_d      = CMD_NOP;
    a_d        = a_q;
    ba_d       = ba_q;
    dm_d       = 2'b11;
    dq_o_d     = dq_o_q;
    dq_t_d     = 1'b1;
    dat_d      = dat_q;
    cke_d      = 1'b1;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    col_d      = col_q;
    ref_cnt_d  = ref_cnt_q;
    ref_run_d  = ref_run_q;
    ref_pend_d = ref_pend_q;
    case (state_q)
      S_INIT_WAIT: if (cnt_q == 16'(T_INIT - 1)) begin
        state_d = S_INIT_PRE; cnt_d = '0; cmd_d = CMD_PRE; a_d = 13'h0400;
      end
      S_INIT_PRE: if (cnt_q == 16'(T_RP - 1)) begin
        state_d = S_INIT_REF1; cnt_d = '0; cmd_d = CMD_REF;
      end
      S_INIT_REF1: if (cnt_q == 16'(T_RFC - 1)) begin
        state_d = S_INIT_REF2; cnt_d = '0; cmd_d = CMD_REF;
      end
      S_INIT_REF2: if (cnt_q == 16'(T_RFC - 1)) begin
        state_d = S_INIT_MRS; cnt_d = '0; cmd_d = CMD_MRS;
        a_d = 13'h0021; ba_d = 2'b00;
      end
      S_INIT_MRS: if (cnt_q == 16'd1) begin
        state_d = S_IDLE; cnt_d = '0;
        ref_run_d = 1'b1; ref_cnt_d = 16'(T_REFI - 1);
      end
      S_IDLE: begin
        cnt_d = '0;
        if (ref_pend_q) begin
          state_d = S_REFRESH; cmd_d = CMD_REF; ref_pend_d = 1'b0;
        end else if (cyc_i && stb_i) begin
          state_d = S_ACT; cmd_d = CMD_ACT;
          ba_d = adr_i[22:21]; a_d = adr_i[20:8];
          col_d = adr_i[7:0]; we_d = we_i; sel_d = sel_i; wdat_d = dat_i;
        end
      end
      S_REFRESH: if (cnt_q == 16'(T_RFC - 1)) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      S_ACT: if (cnt_q == 16'(T_RCD - 1)) begin
        cnt_d = '0;
        a_d = {2'b00, 1'b1, 1'b0, col_q, 1'b0};
        if (we_q) begin
          state_d = S_WRITE; cmd_d = CMD_WRITE;
          dq_t_d = 1'b0; dq_o_d = wdat_q[31:16]; dm_d = ~sel_q[3:2];
        end else begin
          state_d = S_READ; cmd_d = CMD_READ; dm_d = 2'b00;
        end
      end
      S_READ: begin
        dm_d = 2'b00;
        if (cnt_q == 16'd2) dat_d[31:16] = dq_i;
        if (cnt_q == 16'd3) begin
          dat_d[15:0] = dq_i; state_d = S_ACK; cnt_d = '0; dm_d = 2'b11;
        end
      end
      S_WRITE: begin
        if (cnt_q == 16'd0) begin
          dq_t_d = 1'b0; dq_o_d = wdat_q[15:0]; dm_d = ~sel_q[1:0];
        end
        if (cnt_q == 16'(T_WR + T_RP + 1)) begin
          state_d = S_ACK; cnt_d = '0;
        end
      end
      S_ACK: begin
        state_d = S_IDLE; cnt_d = '0;
      end
      default: state_d = S_INIT_WAIT;
    endcase
    if (ref_run_q) begin
      if (ref_cnt_q == 16'd0) begin
        ref_pend_d = 1'b1; ref_cnt_d = 16'(T_REFI - 1);
      end else begin
        ref_cnt_d = ref_cnt_q - 16'd1;
      end
    end
  end

  // State and pin registers, all returning to idle pin levels on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_INIT_WAIT; cnt_q <= '0; cmd_q <= CMD_NOP;
      a_q <= '0; ba_q <= '0; dm_q <= 2'b11; dq_o_q <= '0; dq_t_q <= 1'b1;
      dat_q <= '0; cke_q <= 1'b0; we_q <= 1'b0; sel_q <= '0; wdat_q <= '0;
      col_q <= '0; ref_cnt_q <= '0; ref_run_q <= 1'b0; ref_pend_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; cmd_q <= cmd_d;
      a_q <= a_d; ba_q <= ba_d; dm_q <= dm_d; dq_o_q <= dq_o_d; dq_t_q <= dq_t_d;
      dat_q <= dat_d; cke_q <= cke_d; we_q <= we_d; sel_q <= sel_d; wdat_q <= wdat_d;
      col_q <= col_d; ref_cnt_q <= ref_cnt_d; ref_run_q <= ref_run_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  assign ack_o     = (state_q == S_ACK) && cyc_i && stb_i;
  assign dat_o     = dat_q;
  assign sdram_cke = cke_q;
  assign sdram_cs  = cmd_q[3];
  assign sdram_ras = cmd_q[2];
  assign sdram_cas = cmd_q[1];
  assign sdram_we  = cmd_q[0];
  assign sdram_a   = a_q;
  assign sdram_ba  = ba_q;
  assign sdram_dm  = dm_q;
  assign dq_o      = dq_o_q;
  assign dq_t      = dq_t_q;

endmodule

// File: tb/tb_wb_sdram.sv
// tb_wb_sdram: directed bench for wb_sdram with a small SDRAM pin model.
module tb_wb_sdram;

   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_MRS   = 4'b0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        cyc_i = 1'b0;
   logic        stb_i = 1'b0;
   logic        we_i = 1'b0;
   logic [29:0] adr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] dat_i = '0;
   logic        ack_o;
   logic [31:0] dat_o;
   logic        sdram_cke, sdram_cs, sdram_ras, sdram_cas, sdram_we;
   logic [12:0] sdram_a;
   logic [1:0]  sdram_ba, sdram_dm;
   logic [15:0] dq_i = '0;
   logic [15:0] dq_o;
   logic        dq_t;

   int nChecks = 0;
   int nFail = 0;
   int cycNo = 0;

   logic [3:0]  cmdLog [0:47];
   logic [12:0] aLog   [0:47];
   logic [1:0]  baLog  [0:47];
   logic [1:0]  dmLog  [0:47];
   logic [15:0] dqoLog [0:47];
   logic        dqtLog [0:47];

   wire [3:0] cmd = {sdram_cs, sdram_ras, sdram_cas, sdram_we};

   wb_sdram dut (
      .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
      .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
      .sdram_cke(sdram_cke), .sdram_cs(sdram_cs), .sdram_ras(sdram_ras),
      .sdram_cas(sdram_cas), .sdram_we(sdram_we), .sdram_a(sdram_a),
      .sdram_ba(sdram_ba), .sdram_dm(sdram_dm), .dq_i(dq_i), .dq_o(dq_o), .dq_t(dq_t)
   );

   // 100 MHz system clock.
   always #5 clk_i = ~clk_i;

   // Edge counter used to place requests relative to refresh commands.
   always @(posedge clk_i) cycNo <= cycNo + 1;

   // SDRAM pin model: open rows per bank, byte-masked writes, CL=2 style reads.
   logic [12:0] openRow [0:3];
   logic [15:0] mem [logic [23:0]];
   logic        wrPend = 1'b0;
   logic [23:0] wrKey = '0;
   logic [23:0] rdKey = '0;
   int          rdCount = 0;

   function automatic logic [15:0] memRead(input logic [23:0] k);
      if (mem.exists(k)) return mem[k];
      return 16'h0000;
   endfunction

   task automatic memWrite(input logic [23:0] k, input logic [15:0] d, input logic [1:0] m);
      logic [15:0] w;
      w = memRead(k);
      if (!m[1]) w[15:8] = d[15:8];
      if (!m[0]) w[7:0] = d[7:0];
      mem[k] = w;
   endtask

   // Pin model evaluated mid-cycle so it sees settled registered outputs.
   always @(negedge clk_i) begin
      if (wrPend) begin
         memWrite(wrKey, dq_o, sdram_dm);
         wrPend = 1'b0;
      end
      if (rdCount != 0) begin
         rdCount++;
         if (rdCount == 3) dq_i = memRead(rdKey);
         else if (rdCount == 4) begin
            dq_i = memRead(rdKey + 24'd1);
            rdCount = 0;
         end
      end
      if (rst_i) begin
         case (cmd)
            CMD_ACT: openRow[sdram_ba] = sdram_a;
            CMD_WRITE: begin
               memWrite({sdram_ba, openRow[sdram_ba], sdram_a[8:0]}, dq_o, sdram_dm);
               wrKey = {sdram_ba, openRow[sdram_ba], sdram_a[8:0]} + 24'd1;
               wrPend = 1'b1;
            end
            CMD_READ: begin
               rdKey = {sdram_ba, openRow[sdram_ba], sdram_a[8:0]};
               rdCount = 1;
            end
            default: ;
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                input logic [29:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      cyc_i = cyc; stb_i = stb; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
   endtask

   // One Wishbone access; cycle n of the logs is the n-th cycle after the stb sample.
   task automatic runAccess(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, output int ackAt);
      ackAt = -1;
      @(negedge clk_i);
      applyStimulus(1'b1, 1'b1, we, adr, sel, dat);
      for (int n = 1; n < 48; n++) begin
         @(negedge clk_i);
         cmdLog[n] = cmd; aLog[n] = sdram_a; baLog[n] = sdram_ba;
         dmLog[n] = sdram_dm; dqoLog[n] = dq_o; dqtLog[n] = dq_t;
         if (ack_o) begin
            ackAt = n;
            break;
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Follows the power-up sequence from reset release, with a stalled request early on.
   task automatic waitInit(input string pfx);
      int preAt, ref1At, ref2At, mrsAt, extraCmds, stallAcks;
      logic [12:0] preA, mrsA;
      preAt = -1; ref1At = -1; ref2At = -1; mrsAt = -1;
      extraCmds = 0; stallAcks = 0; preA = '0; mrsA = '0;
      for (int n = 1; n < 10200; n++) begin
         @(negedge clk_i);
         if (n == 1) checkOutput({pfx, "_cke_up"}, 32'(sdram_cke), 32'd1);
         if (n == 100) applyStimulus(1'b1, 1'b1, 1'b0, 30'h123, 4'hF, 32'h0);
         if (n == 200) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
         if (ack_o) stallAcks++;
         if (cmd == CMD_PRE && preAt < 0) begin preAt = n; preA = sdram_a; end
         else if (cmd == CMD_REF && ref1At < 0) ref1At = n;
         else if (cmd == CMD_REF && ref2At < 0) ref2At = n;
         else if (cmd == CMD_MRS && mrsAt < 0) begin mrsAt = n; mrsA = sdram_a; end
         else if (cmd != CMD_NOP) extraCmds++;
         if (mrsAt > 0 && n == mrsAt + 20) break;
      end
      checkOutput({pfx, "_pre_at"}, 32'(preAt), 32'd10000);
      checkOutput({pfx, "_pre_a10"}, 32'(preA[10]), 32'd1);
      checkOutput({pfx, "_ref1_gap"}, 32'(ref1At - preAt), 32'd2);
      checkOutput({pfx, "_ref2_gap"}, 32'(ref2At - ref1At), 32'd7);
      checkOutput({pfx, "_mrs_gap"}, 32'(mrsAt - ref2At), 32'd7);
      checkOutput({pfx, "_mrs_a"}, 32'(mrsA), 32'h021);
      checkOutput({pfx, "_extra_cmds"}, 32'(extraCmds), 32'd0);
      checkOutput({pfx, "_stall_acks"}, 32'(stallAcks), 32'd0);
   endtask

   initial begin
      int ackAt;
      int lastRef;
      int other;
      int refTimes[$];

      // Reset values while rst_i is held low.
      repeat (3) @(negedge clk_i);
      checkOutput("rst_cke", 32'(sdram_cke), 32'd0);
      checkOutput("rst_cmd", 32'(cmd), 32'(CMD_NOP));
      checkOutput("rst_a", 32'(sdram_a), 32'h0);
      checkOutput("rst_ba", 32'(sdram_ba), 32'h0);
      checkOutput("rst_dm", 32'(sdram_dm), 32'h3);
      checkOutput("rst_dqt", 32'(dq_t), 32'd1);
      checkOutput("rst_dqo", 32'(dq_o), 32'h0);
      checkOutput("rst_ack", 32'(ack_o), 32'd0);
      checkOutput("rst_dat", dat_o, 32'h0);
      rst_i = 1'b1;
      waitInit("init");

      $display("[TB] write/read 0x000123");
      runAccess(1'b1, 30'h000123, 4'hF, 32'hDEADBEEF, ackAt);
      checkOutput("wr1_ack_at", 32'(ackAt), 32'd9);
      checkOutput("wr1_act_cmd", 32'(cmdLog[1]), 32'(CMD_ACT));
      checkOutput("wr1_act_ba", 32'(baLog[1]), 32'h0);
      checkOutput("wr1_act_row", 32'(aLog[1]), 32'h0001);
      checkOutput("wr1_gap_nop", 32'(cmdLog[2]), 32'(CMD_NOP));
      checkOutput("wr1_wr_cmd", 32'(cmdLog[3]), 32'(CMD_WRITE));
      checkOutput("wr1_wr_a", 32'(aLog[3]), 32'h0446);
      checkOutput("wr1_b0_dqt", 32'(dqtLog[3]), 32'd0);
      checkOutput("wr1_b0_dq", 32'(dqoLog[3]), 32'hDEAD);
      checkOutput("wr1_b0_dm", 32'(dmLog[3]), 32'h0);
      checkOutput("wr1_b1_dqt", 32'(dqtLog[4]), 32'd0);
      checkOutput("wr1_b1_dq", 32'(dqoLog[4]), 32'hBEEF);
      checkOutput("wr1_released", 32'(dqtLog[5]), 32'd1);
      runAccess(1'b0, 30'h000123, 4'hF, 32'h0, ackAt);
      checkOutput("rd1_ack_at", 32'(ackAt), 32'd7);
      checkOutput("rd1_rd_cmd", 32'(cmdLog[3]), 32'(CMD_READ));
      checkOutput("rd1_rd_a", 32'(aLog[3]), 32'h0446);
      checkOutput("rd1_data", dat_o, 32'hDEADBEEF);

      $display("[TB] byte lane 2 only");
      runAccess(1'b1, 30'h000123, 4'b0100, 32'h11223344, ackAt);
      checkOutput("wr2_ack_at", 32'(ackAt), 32'd9);
      checkOutput("wr2_b0_dm", 32'(dmLog[3]), 32'h2);
      checkOutput("wr2_b0_dq", 32'(dqoLog[3]), 32'h1122);
      checkOutput("wr2_b1_dm", 32'(dmLog[4]), 32'h3);
      runAccess(1'b0, 30'h000123, 4'hF, 32'h0, ackAt);
      checkOutput("rd2_data", dat_o, 32'hDE22BEEF);

      $display("[TB] top of address space");
      runAccess(1'b1, 30'h7FFFFF, 4'hF, 32'h12345678, ackAt);
      checkOutput("wr3_ack_at", 32'(ackAt), 32'd9);
      checkOutput("wr3_act_ba", 32'(baLog[1]), 32'h3);
      checkOutput("wr3_act_row", 32'(aLog[1]), 32'h1FFF);
      checkOutput("wr3_wr_a", 32'(aLog[3]), 32'h05FE);
      runAccess(1'b0, 30'h7FFFFF, 4'hF, 32'h0, ackAt);
      checkOutput("rd3_ack_at", 32'(ackAt), 32'd7);
      checkOutput("rd3_data", dat_o, 32'h12345678);

      $display("[TB] idle refresh rate");
      other = 0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk_i);
         if (cmd == CMD_REF) refTimes.push_back(cycNo);
         else if (cmd != CMD_NOP) other++;
      end
      checkOutput("ref_count_ok", 32'(refTimes.size() >= 9), 32'd1);
      checkOutput("ref_other_cmds", 32'(other), 32'd0);
      for (int i = 1; i < refTimes.size(); i++)
         checkOutput("ref_interval", 32'(refTimes[i] - refTimes[i-1]), 32'd390);

      $display("[TB] refresh collides with request");
      lastRef = -1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk_i);
         if (cmd == CMD_REF) begin
            lastRef = cycNo;
            break;
         end
      end
      checkOutput("ref_found", 32'(lastRef >= 0), 32'd1);
      while (lastRef >= 0 && cycNo < lastRef + 388) @(negedge clk_i);
      runAccess(1'b0, 30'h7FFFFF, 4'hF, 32'h0, ackAt);
      checkOutput("col_ref_first", 32'(cmdLog[1]), 32'(CMD_REF));
      checkOutput("col_act_at9", 32'(cmdLog[9]), 32'(CMD_ACT));
      checkOutput("col_ack_at", 32'(ackAt), 32'd15);
      checkOutput("col_data", dat_o, 32'h12345678);

      $display("[TB] reset during read");
      @(negedge clk_i);
      applyStimulus(1'b1, 1'b1, 1'b0, 30'h000123, 4'hF, 32'h0);
      other = 0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk_i);
         if (ack_o) other++;
         if (n == 3) checkOutput("mid_read_cmd", 32'(cmd), 32'(CMD_READ));
      end
      rst_i = 1'b0;
      #1;
      checkOutput("mid_rst_cke", 32'(sdram_cke), 32'd0);
      checkOutput("mid_rst_cmd", 32'(cmd), 32'(CMD_NOP));
      checkOutput("mid_rst_dqt", 32'(dq_t), 32'd1);
      checkOutput("mid_rst_dm", 32'(sdram_dm), 32'h3);
      checkOutput("mid_rst_dat", dat_o, 32'h0);
      repeat (2) begin
         @(negedge clk_i);
         if (ack_o) other++;
      end
      checkOutput("mid_rst_no_ack", 32'(other), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      rst_i = 1'b1;
      waitInit("reinit");
      runAccess(1'b0, 30'h000123, 4'hF, 32'h0, ackAt);
      checkOutput("rd4_ack_at", 32'(ackAt), 32'd7);
      checkOutput("rd4_data", dat_o, 32'hDE22BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
